// File: rtl/spi_regbank_ctrl.sv
// Bridges SPI slave command words to a register bank; strobes one cycle after value_valid, response registered one cycle after ack/timeout.
// No backpressure: commands arriving while busy, short frames and ack timeouts are dropped and counted in err_count.
module spi_regbank_ctrl #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 15,
   localparam int WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                  system_clk,
   input  logic                  rst,
   input  logic                  cs_start,
   input  logic                  cs_stop,
   input  logic                  value_valid,
   input  logic [WIDTH-1:0]      value_mosi,
   output logic [WIDTH-1:0]      value_miso,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   output logic                  reg_we,
   output logic                  reg_re,
   input  logic                  reg_ack,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  busy,
   output logic [7:0]            err_count
);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       pending;
   logic       cmd_accept;
   logic       done_ack;
   logic       done_timeout;
   logic       overrun;
   logic       short_frame;
   logic       err_inc;
   logic       unused_cs_start;

   // The slave samples value_miso on cs_start; since the response is registered,
   // an update in that same cycle naturally lands in the next frame.
   assign unused_cs_start = cs_start;

   assign pending      = (state != IDLE);
   assign cmd_accept   = !pending && value_valid;
   assign done_ack     = pending && reg_ack;
   assign done_timeout = pending && !reg_ack && (wait_cnt == WAIT_LAST);
   assign overrun      = pending && value_valid;
   assign short_frame  = cs_stop && !value_valid;
   assign err_inc      = done_timeout || overrun || short_frame;

   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (value_valid) begin
               state_nxt = value_mosi[WIDTH-1] ? WRITE : READ;
            end
         end
         WRITE, READ: begin
            if (done_ack || done_timeout) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      reg_we = (state == WRITE);
      reg_re = (state == READ);
      busy   = pending;
   end

   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         reg_addr   <= '0;
         reg_wdata  <= '0;
         wait_cnt   <= '0;
         value_miso <= '0;
         err_count  <= '0;
      end else begin
         if (cmd_accept) begin
            reg_addr  <= value_mosi[WIDTH-2 -: ADDR_WIDTH];
            reg_wdata <= value_mosi[DATA_WIDTH-1:0];
            wait_cnt  <= '0;
         end else if (pending && !done_ack && !done_timeout) begin
            wait_cnt <= wait_cnt + 8'd1;
         end

         if (done_ack) begin
            value_miso <= {1'b1, reg_addr, (state == READ) ? reg_rdata : reg_wdata};
         end else if (done_timeout) begin
            value_miso <= {1'b0, reg_addr, {DATA_WIDTH{1'b0}}};
         end

         // Simultaneous error sources still count as a single event.
         if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_spi_regbank_ctrl.sv
// Directed self-checking bench for spi_regbank_ctrl with default parameters.
module tb_spi_regbank_ctrl;

   logic        clk;
   logic        rst;
   logic        cs_start;
   logic        cs_stop;
   logic        value_valid;
   logic [23:0] value_mosi;
   logic [23:0] value_miso;
   logic [6:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic        reg_ack;
   logic [15:0] reg_rdata;
   logic        busy;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   spi_regbank_ctrl dut (
      .system_clk (clk),
      .rst        (rst),
      .cs_start   (cs_start),
      .cs_stop    (cs_stop),
      .value_valid(value_valid),
      .value_mosi (value_mosi),
      .value_miso (value_miso),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .reg_re     (reg_re),
      .reg_ack    (reg_ack),
      .reg_rdata  (reg_rdata),
      .busy       (busy),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [23:0] word);
      value_mosi  = word;
      value_valid = 1'b1;
      cs_stop     = 1'b1;
      tick();
      value_valid = 1'b0;
      cs_stop     = 1'b0;
   endtask

   initial begin
      int cycles;
      rst = 1'b1; cs_start = 1'b0; cs_stop = 1'b0; value_valid = 1'b0;
      value_mosi = '0; reg_ack = 1'b0; reg_rdata = '0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_we", reg_we, 0);
      chk("rst_re", reg_re, 0);
      chk("rst_miso", value_miso, 0);
      chk("rst_err", err_count, 0);
      chk("rst_addr", reg_addr, 0);
      rst = 1'b0;
      tick();

      // Write with ack on the third strobe cycle
      send(24'h85BEEF);
      chk("wr_we_c1", reg_we, 1);
      chk("wr_addr", reg_addr, 7'h05);
      chk("wr_wdata", reg_wdata, 16'hBEEF);
      chk("wr_busy", busy, 1);
      tick();
      chk("wr_we_c2", reg_we, 1);
      tick();
      chk("wr_we_c3", reg_we, 1);
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      chk("wr_we_done", reg_we, 0);
      chk("wr_busy_done", busy, 0);
      chk("wr_miso", value_miso, 24'h85BEEF);
      chk("wr_err", err_count, 0);

      // Read; ack coincides with cs_start so the old response is still presented
      send(24'h050000);
      chk("rd_re_c1", reg_re, 1);
      chk("rd_we_c1", reg_we, 0);
      tick();
      reg_ack = 1'b1; reg_rdata = 16'h1234; cs_start = 1'b1;
      chk("rd_re_ack", reg_re, 1);
      chk("rd_miso_old", value_miso, 24'h85BEEF);
      tick();
      reg_ack = 1'b0; cs_start = 1'b0;
      chk("rd_miso", value_miso, 24'h851234);
      chk("rd_re_done", reg_re, 0);
      chk("rd_busy_done", busy, 0);

      // Timeout: no ack at all
      send(24'h070000);
      cycles = 0;
      while (reg_re && cycles < 40) begin
         cycles++;
         tick();
      end
      chk("to_re_cycles", cycles, 15);
      chk("to_miso", value_miso, 24'h070000);
      chk("to_err", err_count, 1);
      chk("to_busy", busy, 0);

      // Ack on the 15th wait cycle wins over timeout
      send(24'h030000);
      for (int i = 0; i < 14; i++) tick();
      chk("race_re_c15", reg_re, 1);
      reg_ack = 1'b1; reg_rdata = 16'hA5A5;
      tick();
      reg_ack = 1'b0;
      chk("race_miso", value_miso, 24'h83A5A5);
      chk("race_err", err_count, 1);

      // Overrun during a pending write
      send(24'h8A0011);
      send(24'h81FFFF);
      chk("ovr_addr", reg_addr, 7'h0A);
      chk("ovr_wdata", reg_wdata, 16'h0011);
      chk("ovr_we", reg_we, 1);
      chk("ovr_err", err_count, 2);
      chk("ovr_miso_hold", value_miso, 24'h83A5A5);
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      chk("ovr_miso", value_miso, 24'h8A0011);

      // Short frame, then a stray ack in IDLE
      cs_stop = 1'b1;
      tick();
      cs_stop = 1'b0;
      chk("short_err", err_count, 3);
      chk("short_busy", busy, 0);
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_miso", value_miso, 24'h8A0011);

      // Timeout and short frame in the same cycle count once
      send(24'h010000);
      for (int i = 0; i < 14; i++) tick();
      cs_stop = 1'b1;
      tick();
      cs_stop = 1'b0;
      chk("dual_err", err_count, 4);
      chk("dual_miso", value_miso, 24'h010000);

      // Saturation
      cs_stop = 1'b1;
      for (int i = 0; i < 250; i++) tick();
      chk("sat_254", err_count, 254);
      for (int i = 0; i < 50; i++) tick();
      cs_stop = 1'b0;
      chk("sat_255", err_count, 255);

      // Asynchronous reset in the middle of a read
      send(24'h050000);
      chk("rstmid_re_before", reg_re, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid_re", reg_re, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_miso", value_miso, 0);
      chk("rstmid_err", err_count, 0);
      tick();
      rst = 1'b0;
      tick();
      send(24'h85BEEF);
      chk("post_we", reg_we, 1);
      reg_ack = 1'b1;
      tick();
      reg_ack = 1'b0;
      chk("post_miso", value_miso, 24'h85BEEF);
      chk("post_err", err_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_regbank_ctrl.md
SPI_REGBANK_CTRL -- requirements
Module: spi_regbank_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, register address width.
REQ-002 Parameter DATA_WIDTH, default 16, register data width.
REQ-003 Parameter TIMEOUT, default 15, max cycles waiting for reg_ack; range 1..255.
REQ-004 Localparam WIDTH = 1+ADDR_WIDTH+DATA_WIDTH (24 by default); equals the attached SPI slave word width.
REQ-005 system_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 cs_start  in  1  one-cycle pulse, SPI frame begins; slave samples value_miso this cycle.
REQ-008 cs_stop  in  1  one-cycle pulse, SPI frame ends.
REQ-009 value_valid  in  1  one-cycle pulse with cs_stop, value_mosi holds a complete word.
REQ-010 value_mosi  in  WIDTH  received command: [WIDTH-1]=write flag, next ADDR_WIDTH bits=address, low DATA_WIDTH bits=write data.
REQ-011 value_miso  out  WIDTH  registered response word: [WIDTH-1]=ok, address field, data field.
REQ-012 reg_addr  out  ADDR_WIDTH  register bank address.
REQ-013 reg_wdata  out  DATA_WIDTH  register bank write data.
REQ-014 reg_we  out  1  write request, held until ack or timeout.
REQ-015 reg_re  out  1  read request, held until ack or timeout.
REQ-016 reg_ack  in  1  register bank completion; reg_rdata valid when reg_re and reg_ack both high.
REQ-017 reg_rdata  in  DATA_WIDTH  register bank read data.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 err_count  out  8  saturating protocol error counter.

Function
REQ-020 FSM states IDLE, WRITE, READ; reg_we high exactly in WRITE, reg_re high exactly in READ.
REQ-021 IDLE + value_valid: latch reg_addr/reg_wdata from value_mosi, clear timeout counter, go to WRITE if flag=1 else READ; strobe visible the cycle after value_valid.
REQ-022 WRITE/READ + reg_ack: next cycle state IDLE, strobe low, value_miso = {1, reg_addr, reg_wdata} for write or {1, reg_addr, reg_rdata} for read.
REQ-023 WRITE/READ without reg_ack: timeout counter increments each cycle; on the cycle it reaches TIMEOUT: state IDLE, strobe low, value_miso = {0, reg_addr, 0}, err_count +1.
REQ-024 reg_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
REQ-025 reg_ack in IDLE ignored.
REQ-026 value_valid while not IDLE: command dropped, err_count +1, FSM, strobes and value_miso unaffected.
REQ-027 cs_stop without value_valid (short frame): err_count +1, no command issued, value_miso unchanged.
REQ-028 err_count saturates at 255; multiple errors in one cycle count once.
REQ-029 value_miso changes only on completion/timeout; an update coinciding with cs_start becomes visible the following cycle, so that frame returns the previous response (response of command N returned in frame N+1 or later).
REQ-030 cs_start has no other effect on controller state.

Reset
REQ-031 rst high: immediately state IDLE, reg_we=0, reg_re=0, busy=0, reg_addr=0, reg_wdata=0, value_miso=0, err_count=0, timeout counter=0.
REQ-032 rst asserted mid-WRITE/READ: strobe drops asynchronously, pending command discarded, no error counted.
REQ-033 After rst release, first value_valid handled normally per REQ-021.

Verification
REQ-034 Write: value_mosi=0x85BEEF + value_valid, reg_ack 3 cycles later -> reg_we high 3 cycles, reg_addr=0x05, reg_wdata=0xBEEF, then value_miso=0x85BEEF, busy=0.
REQ-035 Read: value_mosi=0x050000, reg_ack with reg_rdata=0x1234 -> reg_re high until ack, value_miso=0x851234.
REQ-036 Timeout: read 0x070000, reg_ack never -> reg_re high exactly 15 cycles, value_miso=0x070000, err_count=1.
REQ-037 Overrun: second value_valid (0x81FFFF) during pending write -> dropped, reg_addr unchanged, err_count +1; short frame (cs_stop alone) -> err_count +1; 300 errors -> err_count=255.
REQ-038 Reset mid-read: rst during READ -> reg_re=0 same cycle, value_miso=0, err_count=0, next command 0x85BEEF completes normally.
REQ-039 Ack/timeout race: reg_ack on 15th wait cycle -> ok response, err_count unchanged.
